aes128_cbc_ctrl: RTL and testbench

- Sequencer that sits in front of aes128_core and runs multi-block AES-128-CBC encrypt/decrypt over a 128-bit valid/ready stream.
- Owns the core's control inputs and data_i mux: key load, start pulses, chaining (IV) register and pre/post XOR.
- Provides output buffering with backpressure and a block counter.
- Placed between the bus/DMA front-end and the core; shares the core's clk/rst_n.

---
 rtl/aes128_cbc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_aes128_cbc_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_cbc_ctrl.sv
`default_nettype none
// ============================================================================
// aes128_cbc_ctrl : CBC/ECB block sequencer driving aes128_core.   Rev 1.0
// ============================================================================
module aes128_cbc_ctrl #(
  parameter logic CHAIN_EN = 1'b1,
  parameter int   CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid_i,
  input  logic [127:0]     key_i,
  input  logic             iv_valid_i,
  input  logic [127:0]     iv_i,
  output logic             cfg_ready_o,
  input  logic             mode_dec_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             out_last_o,
  output logic             core_start_enc_o,
  output logic             core_start_dec_o,
  output logic             core_load_key_o,
  output logic [127:0]     core_data_o,
  input  logic [127:0]     core_data_i,
  input  logic             core_ready_i,
  input  logic             core_done_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     chain_q, chain_d;
  logic [127:0]     blk_q, blk_d;
  logic [127:0]     res_q, res_d;
  logic             last_q, last_d;
  logic             dec_q, dec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_idle_rdy;
  logic             w_key_acc;
  logic             w_iv_acc;
  logic             w_in_rdy;
  logic             w_blk_acc;
  logic             w_start;
  logic [127:0]     w_issue_data;

  // Ready outputs are held low while reset is asserted, not only after it.
  assign w_idle_rdy = rst_n && (state_q == S_IDLE) && core_ready_i;
  assign w_key_acc  = w_idle_rdy && key_valid_i;
  assign w_iv_acc   = w_idle_rdy && !key_valid_i && iv_valid_i;
  assign w_in_rdy   = w_idle_rdy && !key_valid_i && !iv_valid_i;
  assign w_blk_acc  = w_in_rdy && in_valid_i;
  assign w_start    = (state_q == S_ISSUE) && core_ready_i;

  assign w_issue_data = (CHAIN_EN && !dec_q) ? (blk_q ^ chain_q) : blk_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    chain_d = chain_q;
    blk_d   = blk_q;
    res_d   = res_q;
    last_d  = last_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_key_acc) begin
          key_d   = key_i;
          state_d = S_KEY;
        end else if (w_iv_acc) begin
          chain_d = iv_i;
          cnt_d   = '0;
        end else if (w_blk_acc) begin
          blk_d   = in_data_i;
          last_d  = in_last_i;
          dec_d   = mode_dec_i;
          state_d = S_ISSUE;
        end
      end
      S_KEY: begin
        key_d   = '0;
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (core_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done_i) begin
          if (dec_q) begin
            res_d = CHAIN_EN ? (core_data_i ^ chain_q) : core_data_i;
            if (CHAIN_EN) begin
              chain_d = blk_q;
            end
          end else begin
            res_d = core_data_i;
            if (CHAIN_EN) begin
              chain_d = core_data_i;
            end
          end
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      chain_q <= '0;
      blk_q   <= '0;
      res_q   <= '0;
      last_q  <= 1'b0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      last_q  <= last_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    core_data_o = '0;
    case (state_q)
      S_KEY:          core_data_o = key_q;
      S_ISSUE, S_WAIT: core_data_o = w_issue_data;
      default:        core_data_o = '0;
    endcase
  end

  assign cfg_ready_o      = w_idle_rdy && (key_valid_i || iv_valid_i);
  assign in_ready_o       = w_in_rdy;
  assign core_load_key_o  = (state_q == S_KEY);
  assign core_start_enc_o = w_start && !dec_q;
  assign core_start_dec_o = w_start && dec_q;
  assign out_valid_o      = (state_q == S_OUT);
  assign out_data_o       = out_valid_o ? res_q : '0;
  assign out_last_o       = out_valid_o && last_q;
  assign busy_o           = (state_q != S_IDLE);
  assign blk_cnt_o        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_cbc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes128_cbc_ctrl : vector + randomized bench with a behavioural AES core.
// ============================================================================
module tb_aes128_cbc_ctrl;
  localparam int CNT_W = 32;
  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             key_valid_i, iv_valid_i, cfg_ready_o, mode_dec_i;
  logic [127:0]     key_i, iv_i, in_data_i, out_data_o, core_data_o, core_data_i;
  logic             in_valid_i, in_ready_o, in_last_i, out_valid_o, out_ready_i, out_last_o;
  logic             core_start_enc_o, core_start_dec_o, core_load_key_o;
  logic             core_ready_i, core_done_i, busy_o;
  logic [CNT_W-1:0] blk_cnt_o;

  aes128_cbc_ctrl #(.CHAIN_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid_i(key_valid_i), .key_i(key_i), .iv_valid_i(iv_valid_i), .iv_i(iv_i),
    .cfg_ready_o(cfg_ready_o), .mode_dec_i(mode_dec_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .core_start_enc_o(core_start_enc_o), .core_start_dec_o(core_start_dec_o),
    .core_load_key_o(core_load_key_o), .core_data_o(core_data_o), .core_data_i(core_data_i),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i), .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // ---------------- behavioural AES-128 ----------------
  logic [7:0] sb [256];
  logic [7:0] isb[256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] subb(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv ? isb[gb(s, i)] : sb[gb(s, i)];
    return r;
  endfunction

  function automatic logic [127:0] shiftr(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[127-8*(row+4*c) -: 8] = gb(s, row + 4*(inv ? (c - row + 4) % 4 : (c + row) % 4));
    return r;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s, input bit inv);
    logic [7:0]   base[4];
    logic [7:0]   a[4];
    logic [7:0]   v;
    logic [127:0] r;
    if (inv) base = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     base = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = gb(s, 4*c + k);
      for (int row = 0; row < 4; row++) begin
        v = 8'h00;
        for (int k = 0; k < 4; k++) v = v ^ gm(a[k], base[(k - row + 4) % 4]);
        r[127-8*(4*c+row) -: 8] = v;
      end
    end
    return r;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] p);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand(key);
    s  = p ^ ks[1407 -: 128];
    for (int r = 1; r < 10; r++) s = mixc(shiftr(subb(s, 1'b0), 1'b0), 1'b0) ^ ks[1407-128*r -: 128];
    return shiftr(subb(s, 1'b0), 1'b0) ^ ks[127:0];
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] c);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand(key);
    s  = c ^ ks[127:0];
    for (int r = 9; r > 0; r--) s = mixc(subb(shiftr(s, 1'b1), 1'b1) ^ ks[1407-128*r -: 128], 1'b1);
    return subb(shiftr(s, 1'b1), 1'b1) ^ ks[1407 -: 128];
  endfunction

  // ---------------- core responder ----------------
  logic         m_busy, m_done, m_dec, hold_rdy, spur;
  logic [127:0] m_key, m_din, m_out;
  int           m_cnt, lat_min, lat_max;

  assign core_ready_i = !m_busy && !hold_rdy;
  assign core_done_i  = m_done || spur;
  assign core_data_i  = m_done ? m_out : ~m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dec <= 1'b0;
      m_key <= '0; m_din <= '0; m_out <= '0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (core_load_key_o) m_key <= core_data_o;
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_out  <= m_dec ? aes_dec(m_key, m_din) : aes_enc(m_key, m_din);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (core_ready_i && (core_start_enc_o || core_start_dec_o)) begin
        m_busy <= 1'b1;
        m_din  <= core_data_o;
        m_dec  <= core_start_dec_o;
        m_cnt  <= int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  // Latency rules: start the cycle after accept, result the cycle after done.
  logic pend_start, pend_out;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend_start <= 1'b0;
      pend_out   <= 1'b0;
    end else begin
      if (pend_start && core_ready_i) chk1("start_latency", core_start_enc_o || core_start_dec_o, 1'b1);
      if (pend_out) chk1("out_latency", out_valid_o, 1'b1);
      pend_start <= in_valid_i && in_ready_o;
      pend_out   <= core_done_i && busy_o && !out_valid_o && !core_start_enc_o && !core_start_dec_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_cfg(input bit is_key, input logic [127:0] v);
    int n;
    n = 0;
    @(negedge clk);
    if (is_key) begin key_valid_i = 1'b1; key_i = v; end
    else        begin iv_valid_i  = 1'b1; iv_i  = v; end
    #1;
    while (!cfg_ready_o && n < 100) begin @(negedge clk); #1; n++; end
    if (!cfg_ready_o) tmo("cfg_accept");
    @(negedge clk);
    key_valid_i = 1'b0;
    iv_valid_i  = 1'b0;
  endtask

  task automatic present(input logic [127:0] d, input bit dec, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid_i = 1'b1; in_data_i = d; mode_dec_i = dec; in_last_i = last;
    #1;
    while (!in_ready_o && n < 200) begin @(negedge clk); #1; n++; end
    if (!in_ready_o) tmo("in_accept");
    @(negedge clk);
    in_valid_i = 1'b0; in_data_i = rnd128(); mode_dec_i = $urandom_range(1, 0) == 1; in_last_i = 1'b0;
  endtask

  task automatic get_out(input int bp, output logic [127:0] res, output logic rlast);
    int n;
    n = 0;
    #1;
    while (!out_valid_o && n < 500) begin @(negedge clk); #1; n++; end
    if (!out_valid_o) begin
      tmo("out_valid");
      res = '0; rlast = 1'b0;
      return;
    end
    repeat (bp) begin @(negedge clk); #1; end
    res = out_data_o; rlast = out_last_o;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    #1;
  endtask

  typedef struct {
    logic         ld_key;
    logic [127:0] key;
    logic         ld_iv;
    logic [127:0] iv;
    logic [127:0] din;
    logic         dec;
    logic         last;
    logic [127:0] exp;
    logic         exp_last;
    logic [31:0]  exp_cnt;
  } vec_t;

  vec_t tv[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, exp, chain, key, p, v0, junk;
    logic         rlast, dec, md;
    logic [31:0]  cnt0;
    int           cnt, nb;

    tv[0] = '{1'b1, K0, 1'b1, 128'h0, P0, 1'b0, 1'b1, C0, 1'b1, 32'd1};
    tv[1] = '{1'b0, 128'h0, 1'b1, 128'h0, C0, 1'b1, 1'b1, P0, 1'b1, 32'd1};
    tv[2] = '{1'b1, K1, 1'b1, IV1, P1, 1'b0, 1'b0, C1, 1'b0, 32'd1};
    tv[3] = '{1'b0, 128'h0, 1'b0, 128'h0, P2, 1'b0, 1'b1, C2, 1'b1, 32'd2};
    tv[4] = '{1'b0, 128'h0, 1'b1, IV1, C1, 1'b1, 1'b0, P1, 1'b0, 32'd1};
    tv[5] = '{1'b0, 128'h0, 1'b0, 128'h0, C2, 1'b1, 1'b1, P2, 1'b1, 32'd2};

    key_valid_i = 0; iv_valid_i = 0; key_i = '0; iv_i = '0; mode_dec_i = 0;
    in_valid_i = 1'b1; in_data_i = '0; in_last_i = 0; out_ready_i = 0;
    hold_rdy = 0; spur = 0; lat_min = 0; lat_max = 3;
    build_sbox();

    repeat (3) @(negedge clk);
    #1;
    chk1("rst_in_ready", in_ready_o, 1'b0);
    chk1("rst_cfg_ready", cfg_ready_o, 1'b0);
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_start", core_start_enc_o || core_start_dec_o || core_load_key_o, 1'b0);
    chk("rst_core_data", core_data_o, 128'h0);
    chk("rst_out_data", out_data_o, 128'h0);
    chk("rst_blk_cnt", 128'(blk_cnt_o), 128'h0);
    in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (tv[i].ld_key) do_cfg(1'b1, tv[i].key);
      if (tv[i].ld_iv)  do_cfg(1'b0, tv[i].iv);
      lat_max = int'($urandom_range(4, 0));
      present(tv[i].din, tv[i].dec, tv[i].last);
      get_out(int'($urandom_range(3, 0)), res, rlast);
      chk($sformatf("vec%0d_data", i), res, tv[i].exp);
      chk1($sformatf("vec%0d_last", i), rlast, tv[i].exp_last);
      chk($sformatf("vec%0d_cnt", i), 128'(blk_cnt_o), 128'(tv[i].exp_cnt));
    end

    // key, IV and block offered together: key first, then IV, then block
    @(negedge clk);
    key_valid_i = 1; key_i = K0; iv_valid_i = 1; iv_i = '0;
    in_valid_i = 1; in_data_i = P0; mode_dec_i = 0; in_last_i = 1;
    #1;
    chk1("sim_cfg_key", cfg_ready_o, 1'b1);
    chk1("sim_in_ready0", in_ready_o, 1'b0);
    @(negedge clk); key_valid_i = 0; #1;
    chk1("sim_load_key", core_load_key_o, 1'b1);
    chk("sim_key_data", core_data_o, K0);
    chk1("sim_cfg_in_key", cfg_ready_o, 1'b0);
    @(negedge clk); #1;
    chk1("sim_cfg_iv", cfg_ready_o, 1'b1);
    chk1("sim_in_ready1", in_ready_o, 1'b0);
    chk1("sim_load_key_once", core_load_key_o, 1'b0);
    @(negedge clk); iv_valid_i = 0; #1;
    chk1("sim_in_ready2", in_ready_o, 1'b1);
    @(negedge clk); in_valid_i = 0; #1;
    chk1("sim_busy", busy_o, 1'b1);
    get_out(0, res, rlast);
    chk("sim_data", res, C0);
    chk("sim_cnt", 128'(blk_cnt_o), 128'd1);

    // core stall in ISSUE, then 10 cycles of output backpressure
    p = rnd128();
    exp = aes_enc(K0, p ^ C0);
    @(negedge clk);
    in_valid_i = 1; in_data_i = p; mode_dec_i = 0; in_last_i = 0;
    #1;
    chk1("bp_in_ready", in_ready_o, 1'b1);
    @(negedge clk);
    hold_rdy = 1; in_data_i = rnd128();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("hold_no_start", core_start_enc_o || core_start_dec_o, 1'b0);
      chk1("hold_busy", busy_o, 1'b1);
      @(negedge clk);
    end
    hold_rdy = 0;
    nb = 0;
    #1;
    while (!out_valid_o && nb < 100) begin @(negedge clk); #1; nb++; end
    if (!out_valid_o) tmo("bp_out_valid");
    v0 = out_data_o;
    cnt0 = blk_cnt_o;
    chk("bp_data", v0, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk1("bp_valid_stable", out_valid_o, 1'b1);
      chk("bp_data_stable", out_data_o, v0);
      chk1("bp_in_ready", in_ready_o, 1'b0);
      chk1("bp_no_start", core_start_enc_o || core_start_dec_o, 1'b0);
    end
    out_ready_i = 1;
    @(negedge clk);
    out_ready_i = 0; in_valid_i = 0;
    #1;
    chk("bp_cnt_inc", 128'(blk_cnt_o), 128'(cnt0 + 32'd1));
    @(negedge clk); #1;
    chk("bp_cnt_once", 128'(blk_cnt_o), 128'(cnt0 + 32'd1));
    chk1("bp_idle", busy_o, 1'b0);

    // done pulse while idle must be ignored
    @(negedge clk); spur = 1;
    @(negedge clk); spur = 0; #1;
    chk1("spur_out_valid", out_valid_o, 1'b0);
    chk1("spur_busy", busy_o, 1'b0);
    chk("spur_cnt", 128'(blk_cnt_o), 128'(cnt0 + 32'd1));

    // random messages against a CBC reference
    for (int m = 0; m < 4; m++) begin
      key = rnd128();
      chain = rnd128();
      do_cfg(1'b1, key);
      do_cfg(1'b0, chain);
      cnt = 0;
      nb = int'($urandom_range(5, 1));
      md = $urandom_range(1, 0) == 1;
      lat_max = int'($urandom_range(6, 0));
      for (int b = 0; b < nb; b++) begin
        dec = ($urandom_range(3, 0) == 0) ? !md : md;
        p = rnd128();
        if (!dec) begin
          exp = aes_enc(key, p ^ chain);
          chain = exp;
        end else begin
          exp = aes_dec(key, p) ^ chain;
          chain = p;
        end
        cnt++;
        present(p, dec, b == nb - 1);
        get_out(int'($urandom_range(4, 0)), res, rlast);
        chk($sformatf("rnd%0d_%0d_data", m, b), res, exp);
        chk1($sformatf("rnd%0d_%0d_last", m, b), rlast, b == nb - 1);
        chk($sformatf("rnd%0d_%0d_cnt", m, b), 128'(blk_cnt_o), 128'(cnt));
      end
    end

    // reset while waiting for the core
    lat_min = 20; lat_max = 20;
    junk = rnd128();
    present(junk, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk1("rw_busy_before", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rw_busy", busy_o, 1'b0);
    chk1("rw_out_valid", out_valid_o, 1'b0);
    chk1("rw_core_ctl", core_start_enc_o || core_start_dec_o || core_load_key_o, 1'b0);
    chk("rw_core_data", core_data_o, 128'h0);
    chk("rw_out_data", out_data_o, 128'h0);
    chk("rw_cnt", 128'(blk_cnt_o), 128'h0);
    chk1("rw_ready", in_ready_o || cfg_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    lat_min = 0; lat_max = 3;
    do_cfg(1'b1, K1);
    do_cfg(1'b0, IV1);
    present(P1, 1'b0, 1'b1);
    get_out(1, res, rlast);
    chk("rw_after_data", res, C1);
    chk1("rw_after_last", rlast, 1'b1);
    chk("rw_after_cnt", 128'(blk_cnt_o), 128'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
